// File: rtl/cam_capture_rgb565.sv
// OV5640 DVP capture: input registering, post-configuration frame skip, RGB565 byte packing.
// Define CAPTURE_STATS_EN to add per-frame line/pixel size checking on a size_err output.
module cam_capture_rgb565 #(
   parameter int WAIT_FRAME = 10,
   parameter int H_PIXEL    = 1024,
   parameter int V_PIXEL    = 768
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        cfg_done,
   input  logic        cam_vsync,
   input  logic        cam_href,
   input  logic [7:0]  cam_data,
   output logic        cmos_frame_vsync,
   output logic        cmos_frame_href,
   output logic        cmos_frame_valid,
   output logic [15:0] cmos_frame_data,
`ifdef CAPTURE_STATS_EN
   output logic        size_err,
`endif
   output logic        byte_err
);

   typedef enum logic [1:0] {
      WAIT_CFG,
      SKIP,
      RUN
   } state_t;

   localparam logic [7:0] WAIT_CNT = 8'(WAIT_FRAME);

   state_t     state;
   state_t     state_next;
   logic [7:0] frame_cnt;
   logic [7:0] frame_cnt_next;

   logic       vsync_d1;
   logic       vsync_d2;
   logic       href_d1;
   logic [7:0] data_d1;
   logic [7:0] data_hi;
   logic       phase;
   logic       vs_rise;
   logic       run;
   logic       pixel_done;

   assign vs_rise    = vsync_d1 & ~vsync_d2;
   assign run        = (state == RUN);
   assign pixel_done = href_d1 & phase;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         vsync_d1 <= 1'b0;
         vsync_d2 <= 1'b0;
         href_d1  <= 1'b0;
         data_d1  <= 8'h00;
      end else begin
         vsync_d1 <= cam_vsync;
         vsync_d2 <= vsync_d1;
         href_d1  <= cam_href;
         data_d1  <= cam_data;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= WAIT_CFG;
         frame_cnt <= 8'h00;
      end else begin
         state     <= state_next;
         frame_cnt <= frame_cnt_next;
      end
   end

   // The vs_rise that finds the counter at WAIT_CNT is itself the start of the first forwarded frame.
   always_comb begin
      state_next     = state;
      frame_cnt_next = frame_cnt;
      case (state)
         WAIT_CFG: begin
            frame_cnt_next = 8'h00;
            if (cfg_done) begin
               state_next = SKIP;
            end
         end
         SKIP: begin
            if (vs_rise) begin
               if (frame_cnt == WAIT_CNT) begin
                  state_next = RUN;
               end else begin
                  frame_cnt_next = frame_cnt + 8'd1;
               end
            end
         end
         RUN: begin
            state_next = RUN;
         end
         default: begin
            state_next     = WAIT_CFG;
            frame_cnt_next = 8'h00;
         end
      endcase
      if (!cfg_done) begin
         state_next     = WAIT_CFG;
         frame_cnt_next = 8'h00;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         phase   <= 1'b0;
         data_hi <= 8'h00;
      end else if (href_d1) begin
         phase <= ~phase;
         if (!phase) begin
            data_hi <= data_d1;
         end
      end else begin
         phase <= 1'b0;
      end
   end

   // Gating uses the current state, so a cfg_done drop silences outputs one edge after it is seen.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cmos_frame_vsync <= 1'b0;
         cmos_frame_href  <= 1'b0;
         cmos_frame_valid <= 1'b0;
         cmos_frame_data  <= 16'h0000;
         byte_err         <= 1'b0;
      end else begin
         cmos_frame_vsync <= run & vsync_d1;
         cmos_frame_href  <= run & href_d1;
         cmos_frame_valid <= run & pixel_done;
         if (run && pixel_done) begin
            cmos_frame_data <= {data_hi, data_d1};
         end
         byte_err <= ~href_d1 & phase;
      end
   end

`ifdef CAPTURE_STATS_EN
   localparam logic [11:0] H_CNT = 12'(H_PIXEL);
   localparam logic [11:0] V_CNT = 12'(V_PIXEL);

   logic        href_d2;
   logic        href_fall;
   logic [11:0] pix_cnt;
   logic [11:0] line_cnt;
   logic        line_bad;

   assign href_fall = href_d2 & ~href_d1;

   // The entry vs_rise happens while still in SKIP, so the first frame boundary is never checked.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         href_d2  <= 1'b0;
         pix_cnt  <= 12'h000;
         line_cnt <= 12'h000;
         line_bad <= 1'b0;
         size_err <= 1'b0;
      end else begin
         href_d2 <= href_d1;
         if (href_fall) begin
            pix_cnt <= 12'h000;
         end else if (pixel_done) begin
            pix_cnt <= pix_cnt + 12'd1;
         end
         if (vs_rise) begin
            line_cnt <= 12'h000;
         end else if (href_fall) begin
            line_cnt <= line_cnt + 12'd1;
         end
         size_err <= vs_rise & run & ((line_cnt != V_CNT) | line_bad);
         if (vs_rise || !run) begin
            line_bad <= 1'b0;
         end else if (href_fall && (pix_cnt != H_CNT)) begin
            line_bad <= 1'b1;
         end
      end
   end
`else
   logic unused_stats;
   assign unused_stats = ^{12'(H_PIXEL), 12'(V_PIXEL)};
`endif

endmodule

// File: tb/tb_cam_capture_rgb565.sv
// Directed bench for cam_capture_rgb565: frame skip, pixel packing, latency, odd bytes, gating, reset.
// Size checking is exercised when CAPTURE_STATS_EN is defined.
module tb_cam_capture_rgb565;

   logic        sys_clk   = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        cfg_done  = 1'b0;
   logic        cam_vsync = 1'b0;
   logic        cam_href  = 1'b0;
   logic [7:0]  cam_data  = 8'h00;
   logic        cmos_frame_vsync;
   logic        cmos_frame_href;
   logic        cmos_frame_valid;
   logic [15:0] cmos_frame_data;
   logic        byte_err;
`ifdef CAPTURE_STATS_EN
   logic        size_err;
`endif

   int checks       = 0;
   int errors       = 0;
   int cyc          = 0;
   int valid_cnt    = 0;
   int href_cnt     = 0;
   int vsync_cnt    = 0;
   int err_cnt      = 0;
   int size_cnt     = 0;
   int last_err_cyc = 0;
   int valid_cyc_q[$];
   logic [15:0] valid_data_q[$];

   cam_capture_rgb565 #(
      .WAIT_FRAME(2),
      .H_PIXEL   (4),
      .V_PIXEL   (2)
   ) dut (
      .sys_clk         (sys_clk),
      .sys_rst_n       (sys_rst_n),
      .cfg_done        (cfg_done),
      .cam_vsync       (cam_vsync),
      .cam_href        (cam_href),
      .cam_data        (cam_data),
      .cmos_frame_vsync(cmos_frame_vsync),
      .cmos_frame_href (cmos_frame_href),
      .cmos_frame_valid(cmos_frame_valid),
      .cmos_frame_data (cmos_frame_data),
`ifdef CAPTURE_STATS_EN
      .size_err        (size_err),
`endif
      .byte_err        (byte_err)
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) cyc <= cyc + 1;

   // Output monitor samples just after each rising edge.
   always @(posedge sys_clk) begin
      #1;
      if (cmos_frame_valid) begin
         valid_cnt++;
         valid_cyc_q.push_back(cyc);
         valid_data_q.push_back(cmos_frame_data);
      end
      if (cmos_frame_href)  href_cnt++;
      if (cmos_frame_vsync) vsync_cnt++;
      if (byte_err) begin
         err_cnt++;
         last_err_cyc = cyc;
      end
`ifdef CAPTURE_STATS_EN
      if (size_err) size_cnt++;
`endif
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic vs, input logic hr, input logic [7:0] d);
      @(negedge sys_clk);
      cam_vsync = vs;
      cam_href  = hr;
      cam_data  = d;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) applyStimulus(1'b0, 1'b0, 8'h00);
   endtask

   task automatic send_frame(input int lines, input int nbytes);
      repeat (4) applyStimulus(1'b1, 1'b0, 8'h00);
      idle_cycles(4);
      for (int l = 0; l < lines; l++) begin
         for (int b = 0; b < nbytes; b++) applyStimulus(1'b0, 1'b1, 8'(l * 16 + b));
         idle_cycles(4);
      end
      idle_cycles(6);
   endtask

   task automatic clear_counts();
      valid_cnt = 0;
      href_cnt  = 0;
      vsync_cnt = 0;
      err_cnt   = 0;
      size_cnt  = 0;
      valid_cyc_q.delete();
      valid_data_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int start_cyc;
      int fall_cyc;
      int gate_cyc;

      // Reset with busy inputs: outputs must stay cleared
      repeat (3) @(negedge sys_clk);
      cam_vsync = 1'b1;
      cam_href  = 1'b1;
      cam_data  = 8'hAA;
      cfg_done  = 1'b1;
      repeat (2) @(negedge sys_clk);
      checkOutput("reset_outputs",
                  32'({cmos_frame_vsync, cmos_frame_href, cmos_frame_valid, byte_err, cmos_frame_data}), 32'h0);
      cam_vsync = 1'b0;
      cam_href  = 1'b0;
      cam_data  = 8'h00;
      sys_rst_n = 1'b1;

      // Frame skip then forwarding
      clear_counts();
      send_frame(4, 8);
      send_frame(4, 8);
      checkOutput("skip_valid", 32'(valid_cnt), 32'd0);
      clear_counts();
      send_frame(4, 8);
      checkOutput("f3_valid", 32'(valid_cnt), 32'd16);
      checkOutput("f3_vsync", 32'(vsync_cnt), 32'd3);
      checkOutput("f3_href", 32'(href_cnt), 32'd32);
      checkOutput("f3_last_data", 32'(cmos_frame_data), 32'h3637);
      clear_counts();
      send_frame(4, 8);
      checkOutput("f4_valid", 32'(valid_cnt), 32'd16);
      checkOutput("f4_vsync", 32'(vsync_cnt), 32'd4);

      // Pixel latency and packing
      clear_counts();
      applyStimulus(1'b0, 1'b1, 8'hF8);
      start_cyc = cyc;
      applyStimulus(1'b0, 1'b1, 8'h00);
      applyStimulus(1'b0, 1'b1, 8'h07);
      applyStimulus(1'b0, 1'b1, 8'hE0);
      idle_cycles(6);
      checkOutput("lat_count", 32'(valid_cyc_q.size()), 32'd2);
      while (valid_cyc_q.size() < 2) begin
         valid_cyc_q.push_back(-1);
         valid_data_q.push_back(16'hxxxx);
      end
      checkOutput("lat_first", 32'(valid_cyc_q[0] - start_cyc), 32'd3);
      checkOutput("lat_second", 32'(valid_cyc_q[1] - start_cyc), 32'd5);
      checkOutput("data_first", 32'(valid_data_q[0]), 32'hF800);
      checkOutput("data_second", 32'(valid_data_q[1]), 32'h07E0);

      // Odd-length line
      clear_counts();
      for (int b = 0; b < 7; b++) applyStimulus(1'b0, 1'b1, 8'(17 * (b + 1)));
      applyStimulus(1'b0, 1'b0, 8'h00);
      fall_cyc = cyc;
      idle_cycles(6);
      checkOutput("odd_valid", 32'(valid_cnt), 32'd3);
      checkOutput("odd_err_count", 32'(err_cnt), 32'd1);
      checkOutput("odd_err_delay", 32'(last_err_cyc - fall_cyc), 32'd2);
      checkOutput("odd_last_data", 32'(cmos_frame_data), 32'h5566);

      // cfg_done dropped mid-line
      clear_counts();
      gate_cyc = 0;
      for (int b = 0; b < 16; b++) begin
         applyStimulus(1'b0, 1'b1, 8'(b));
         if (b == 5) begin
            cfg_done = 1'b0;
            gate_cyc = cyc;
         end
         if (b == 6) checkOutput("gate_href_first", 32'(cmos_frame_href), 32'd1);
         if (b == 7) begin
            checkOutput("gate_href_second", 32'(cmos_frame_href), 32'd0);
            checkOutput("gate_cycle", 32'(cyc - gate_cyc), 32'd2);
            clear_counts();
         end
      end
      idle_cycles(4);
      send_frame(4, 8);
      checkOutput("gate_valid", 32'(valid_cnt), 32'd0);
      checkOutput("gate_href", 32'(href_cnt), 32'd0);
      checkOutput("gate_vsync", 32'(vsync_cnt), 32'd0);
      cfg_done = 1'b1;
      clear_counts();
      send_frame(4, 8);
      send_frame(4, 8);
      checkOutput("reskip_valid", 32'(valid_cnt), 32'd0);
      clear_counts();
      send_frame(4, 8);
      checkOutput("rerun_valid", 32'(valid_cnt), 32'd16);

      // Asynchronous reset mid-pixel
      applyStimulus(1'b0, 1'b1, 8'hA1);
      applyStimulus(1'b0, 1'b1, 8'hB2);
      applyStimulus(1'b0, 1'b1, 8'hC3);
      checkOutput("pre_reset_href", 32'(cmos_frame_href), 32'd1);
      checkOutput("pre_reset_data", 32'(cmos_frame_data), 32'h3637);
      #3;
      sys_rst_n = 1'b0;
      #1;
      checkOutput("async_reset_outputs",
                  32'({cmos_frame_vsync, cmos_frame_href, cmos_frame_valid, byte_err, cmos_frame_data}), 32'h0);
      idle_cycles(2);
      sys_rst_n = 1'b1;
      clear_counts();
      send_frame(4, 8);
      checkOutput("post_reset_valid", 32'(valid_cnt), 32'd0);

`ifdef CAPTURE_STATS_EN
      // Size checking with H_PIXEL=4, V_PIXEL=2
      @(negedge sys_clk);
      sys_rst_n = 1'b0;
      idle_cycles(2);
      sys_rst_n = 1'b1;
      send_frame(2, 8);
      send_frame(2, 8);
      send_frame(2, 8);
      clear_counts();
      send_frame(3, 8);
      checkOutput("size_ok", 32'(size_cnt), 32'd0);
      clear_counts();
      send_frame(2, 8);
      checkOutput("size_bad_lines", 32'(size_cnt), 32'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
